alu_ctrl_mdu: RTL and testbench
===============================

# alu_ctrl_mdu

ALU control decoder with an integrated multi-cycle multiply/divide sequencer for the MIPS core. The decoder maps `alu_op` and the full 6-bit function field onto the 4-bit ALU operation code each cycle. R-type mult/div instructions start an iterative shift-add / restoring-divide engine that writes the HI/LO registers. Later HI/LO accesses and MDU ops are interlocked through `stall`. The block sits between the main control unit and the ALU/register-file writeback mux.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 4).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: the current instruction is live this cycle.
- `alu_op` in 2: from main control. 00 = lw/sw, 01 = beq/bne, 10 = R-type, 11 = addi.
- `funct` in 6: instruction function field.
- `rs_val` in WIDTH: rs operand (multiplicand, dividend, or mthi/mtlo data).
- `rt_val` in WIDTH: rt operand (multiplier or divisor).
- `alu_ctrl` out 4: ALU operation code, combinational.
- `stall` out 1: freeze PC and instruction this cycle, combinational.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `mdu_done` out 1: one-cycle pulse when a mult/div result lands in HI/LO.
- `div_by_zero` out 1: sticky flag for the last division.

## Operation
- **alu_ctrl decode** (combinational, no state):
  - `alu_op` 00 or 11 → 0010 (add). `alu_op` 01 → 0110 (sub).
  - `alu_op` 10, full 6-bit match:
    - 100000/100001 → 0010
    - 100010/100011 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 100110 → 0011 (xor)
    - 100111 → 1100 (nor)
    - 101010 → 0111 (slt)
    - 101011 → 1000 (sltu)
  - Any other funct → 0010.
- **MDU ops** (`alu_op` = 10): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- **FSM states:** IDLE, MUL, DIV, FIX.
  - IDLE → MUL or DIV: on `valid` & mult/div funct & `!stall`. Latch operands (magnitudes for signed forms, plus result sign bits). Clear the iteration counter. Clear `div_by_zero`.
  - MUL / DIV: one bit per cycle. After WIDTH iterations → FIX.
  - MUL: 2·WIDTH-bit shift-add product.
  - DIV: restoring division. Quotient goes to LO, remainder to HI.
  - FIX: apply sign correction and write HI/LO. Pulse `mdu_done` on the next cycle. Return to IDLE.
- **Signed rules:**
  - Product is a full 2·WIDTH-bit two's complement value, HI = upper half.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Minimum-negative ÷ −1 gives LO = 1 followed by WIDTH−1 zeros, HI = 0.
- **Division by zero:** HI = `rs_val`, LO = all ones, `div_by_zero` = 1. The flag holds until the next mult/div is accepted.
- **mthi/mtlo:** write `rs_val` into HI/LO at the clock edge when not stalled.
- **mfhi/mflo:** the datapath reads the `hi`/`lo` ports. This block sequences nothing for them.
- **stall:** high when state ≠ IDLE & `valid` & funct is any MDU op.
  - Non-MDU instructions never stall, so they overlap with the engine.
  - While stalled, no MDU op is accepted and no HI/LO write occurs.

## Timing
- Accept at clock edge E0. Iterations at E1..E_WIDTH. FIX write at E_{WIDTH+1}.
- HI/LO new values are visible WIDTH+1 cycles after E0 (33 cycles at WIDTH = 32).
- `mdu_done` is high for exactly the cycle after E_{WIDTH+1}.
- Busy (state ≠ IDLE) spans cycles E0+ through E_{WIDTH+1}−.
- An MDU op presented in the first IDLE cycle after FIX is accepted with no bubble.
- **Reset values:** state IDLE, `hi` = 0, `lo` = 0, `mdu_done` = 0, `div_by_zero` = 0, counter 0.
  - `stall` is low after reset because state is IDLE.
- **Reset asserted mid-operation:** the operation is aborted immediately and asynchronously. HI/LO read 0, and no `mdu_done` pulse follows.
- `valid` low in IDLE: nothing is accepted and HI/LO hold.

## Test plan
- **Decode sweep:** every `alu_op` × listed funct, plus one undefined funct.
  - Example: `alu_op` 10 with funct 100111 → `alu_ctrl` 1100; funct 111111 → 0010.
- **mult:** `rs` = 0xFFFFFFFE (−2), `rt` = 0x00000003.
  - `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA.
  - `mdu_done` pulses 33 cycles after accept.
  - The same operands with multu → `hi` = 0x00000002, `lo` = 0xFFFFFFFA.
- **div:** −7 ÷ 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - 0x80000000 ÷ 0xFFFFFFFF (div) → `lo` = 0x80000000, `hi` = 0.
  - divu 7 ÷ 0 → `hi` = 7, `lo` = 0xFFFFFFFF, `div_by_zero` = 1.
- **Interlock:** issue mult, then on the next cycle an add (no stall), then mflo.
  - `stall` is high until the cycle after FIX.
  - mthi issued while busy does not modify HI.
- **Reset abort:** pull `rst_n` low 10 cycles into a div.
  - `hi` = `lo` = 0, no `mdu_done` pulse.
  - A new mult is accepted on the first cycle after release.

Source files
------------

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu
//   ALU control decoder plus an iterative multiply/divide sequencer that
//   owns the HI/LO registers. The decoder is purely combinational; the
//   sequencer runs one bit per cycle and interlocks later MDU ops via stall.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   valid          instruction in decode is live
//   alu_op, funct  main-control ALU op class and R-type function field
//   rs_val, rt_val operands (multiplicand/dividend/mt data, multiplier/divisor)
//   alu_ctrl       4-bit ALU operation code (combinational)
//   stall          freeze fetch/decode this cycle (combinational)
//   hi, lo         HI/LO registers
//   mdu_done       one-cycle pulse after a mult/div result lands in HI/LO
//   div_by_zero    sticky flag for the most recent division
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | engine free; mult/div accepted, mthi/mtlo write HI/LO
// S_MUL  | shift-add, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
// S_FIX  | sign correction and HI/LO writeback, then back to idle
module alu_ctrl_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_ctrl,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mdu_done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;   // partial product upper half / remainder
    logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;   // multiplier bits / dividend -> quotient
    logic [WIDTH-1:0]  opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic              neg_hi_q, neg_hi_d;   // div: negate remainder
    logic              neg_lo_q, neg_lo_d;   // mul: negate product, div: negate quotient
    logic              op_div_q, op_div_d;
    logic              dbz_pend_q, dbz_pend_d;
    logic              dbz_q, dbz_d;
    logic              done_q, done_d;

    logic              is_rtype;
    logic              is_mdu_f;
    logic              is_muldiv_f;
    logic              busy;
    logic              start;
    logic              is_signed;
    logic              rs_neg, rt_neg;
    logic [WIDTH-1:0]  rs_mag, rt_mag;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH:0]    div_diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        alu_ctrl = 4'b0010;
        case (alu_op)
            2'b01: alu_ctrl = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000, 6'b100001: alu_ctrl = 4'b0010;
                    6'b100010, 6'b100011: alu_ctrl = 4'b0110;
                    6'b100100:            alu_ctrl = 4'b0000;
                    6'b100101:            alu_ctrl = 4'b0001;
                    6'b100110:            alu_ctrl = 4'b0011;
                    6'b100111:            alu_ctrl = 4'b1100;
                    6'b101010:            alu_ctrl = 4'b0111;
                    6'b101011:            alu_ctrl = 4'b1000;
                    default:              alu_ctrl = 4'b0010;
                endcase
            end
            default: alu_ctrl = 4'b0010;
        endcase
    end

    // mult/multu/div/divu are 0110xx, mfhi/mthi/mflo/mtlo are 0100xx.
    assign is_rtype    = (alu_op == 2'b10);
    assign is_muldiv_f = is_rtype && (funct[5:2] == 4'b0110);
    assign is_mdu_f    = is_muldiv_f || (is_rtype && (funct[5:2] == 4'b0100));
    assign busy        = (state_q != S_IDLE);
    assign stall       = busy && valid && is_mdu_f;
    assign start       = valid && is_muldiv_f && !busy;

    // funct[0] set selects the unsigned variant, funct[1] selects divide.
    assign is_signed = ~funct[0];
    assign rs_neg    = is_signed && rs_val[WIDTH-1];
    assign rt_neg    = is_signed && rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod      = neg_lo_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        neg_hi_d   = neg_hi_q;
        neg_lo_d   = neg_lo_q;
        op_div_d   = op_div_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_div_d = funct[1];
                    cnt_d    = '0;
                    dbz_d    = 1'b0;
                    acc_hi_d = '0;
                    if (funct[1]) begin
                        state_d = S_DIV;
                        if (rt_val == '0) begin
                            // A zero divisor run unsigned on the raw dividend leaves
                            // remainder = rs_val and quotient = all ones.
                            acc_lo_d   = rs_val;
                            opnd_d     = '0;
                            neg_hi_d   = 1'b0;
                            neg_lo_d   = 1'b0;
                            dbz_pend_d = 1'b1;
                        end else begin
                            acc_lo_d   = rs_mag;
                            opnd_d     = rt_mag;
                            neg_hi_d   = rs_neg;
                            neg_lo_d   = rs_neg ^ rt_neg;
                            dbz_pend_d = 1'b0;
                        end
                    end else begin
                        state_d    = S_MUL;
                        acc_lo_d   = rt_mag;
                        opnd_d     = rs_mag;
                        neg_hi_d   = 1'b0;
                        neg_lo_d   = rs_neg ^ rt_neg;
                        dbz_pend_d = 1'b0;
                    end
                end else if (valid && is_rtype && funct == F_MTHI) begin
                    hi_d = rs_val;
                end else if (valid && is_rtype && funct == F_MTLO) begin
                    lo_d = rs_val;
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end else if (div_shift >= {1'b0, opnd_q}) begin
                    acc_hi_d = div_diff[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_hi_d = div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (op_div_q) begin
                    hi_d  = neg_hi_q ? -acc_hi_q : acc_hi_q;
                    lo_d  = neg_lo_q ? -acc_lo_q : acc_lo_q;
                    dbz_d = dbz_pend_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            neg_hi_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            op_div_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            neg_hi_q   <= neg_hi_d;
            neg_lo_q   <= neg_lo_d;
            op_div_q   <= op_div_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign mdu_done    = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mdu_done;
    logic        div_by_zero;

    alu_ctrl_mdu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .alu_op     (alu_op),
        .funct      (funct),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .alu_ctrl   (alu_ctrl),
        .stall      (stall),
        .hi         (hi),
        .lo         (lo),
        .mdu_done   (mdu_done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every mdu_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && mdu_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got pulse expected none");
            end else begin
                e = sb_q.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
            end
        end
    end

    task automatic dec(input string name, input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] exp);
        valid  = 1'b0;
        alu_op = op;
        funct  = f;
        #1;
        chk(name, {28'b0, alu_ctrl}, {28'b0, exp});
    endtask

    // Issues one mult/div from a posedge+1 slot, queues its expected result
    // and checks the done latency; returns at posedge+1.
    task automatic run_mdu(input string name, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input logic e_dbz);
        exp_t e;
        int cyc;
        e.hi = e_hi;
        e.lo = e_lo;
        e.dbz = e_dbz;
        sb_q.push_back(e);
        valid  = 1'b1;
        alu_op = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        valid = 1'b0;
        funct = 6'b100000;
        cyc = 0;
        while (cyc < 60) begin
            @(negedge clk);
            if (mdu_done) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({name, "_latency"}, cyc, 33);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [31:0] hi_before;

        rst_n  = 1'b0;
        valid  = 1'b1;
        alu_op = 2'b10;
        funct  = 6'b010000;
        rs_val = '0;
        rt_val = '0;
        #3;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_done", {31'b0, mdu_done}, 32'h0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dec("dec_lw",   2'b00, 6'b100010, 4'b0010);
        dec("dec_beq",  2'b01, 6'b100000, 4'b0110);
        dec("dec_addi", 2'b11, 6'b100111, 4'b0010);
        dec("dec_add",  2'b10, 6'b100000, 4'b0010);
        dec("dec_addu", 2'b10, 6'b100001, 4'b0010);
        dec("dec_sub",  2'b10, 6'b100010, 4'b0110);
        dec("dec_subu", 2'b10, 6'b100011, 4'b0110);
        dec("dec_and",  2'b10, 6'b100100, 4'b0000);
        dec("dec_or",   2'b10, 6'b100101, 4'b0001);
        dec("dec_xor",  2'b10, 6'b100110, 4'b0011);
        dec("dec_nor",  2'b10, 6'b100111, 4'b1100);
        dec("dec_slt",  2'b10, 6'b101010, 4'b0111);
        dec("dec_sltu", 2'b10, 6'b101011, 4'b1000);
        dec("dec_undef",2'b10, 6'b111111, 4'b0010);
        dec("dec_mult", 2'b10, 6'b011000, 4'b0010);
        @(posedge clk);
        #1;
        chk("idle_hold_hi", hi, 32'h0);

        run_mdu("mult",   6'b011000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_mdu("multu",  6'b011001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0);
        run_mdu("div",    6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_mdu("divmin", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_mdu("divu",   6'b011011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0);
        run_mdu("divs0",  6'b011010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        run_mdu("divu0",  6'b011011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1);
        chk("dbz_sticky", {31'b0, div_by_zero}, 32'h1);

        // Interlock: mult, then overlapping add, a blocked mthi, then mflo held.
        begin
            exp_t e;
            e.hi = 32'h00000003;
            e.lo = 32'h00030000;
            e.dbz = 1'b0;
            sb_q.push_back(e);
        end
        hi_before = hi;
        valid  = 1'b1;
        alu_op = 2'b10;
        funct  = 6'b011000;
        rs_val = 32'h00010001;
        rt_val = 32'h00030000;
        @(posedge clk);
        #1;
        funct = 6'b100000;
        @(negedge clk);
        chk("ovl_add_stall", {31'b0, stall}, 32'h0);
        chk("ovl_add_ctrl", {28'b0, alu_ctrl}, 32'h2);
        chk("dbz_cleared", {31'b0, div_by_zero}, 32'h0);
        @(posedge clk);
        #1;
        funct  = 6'b010001;
        rs_val = 32'hDEADBEEF;
        @(negedge clk);
        chk("mthi_busy_stall", {31'b0, stall}, 32'h1);
        @(posedge clk);
        #1;
        chk("mthi_busy_hi", hi, hi_before);
        funct = 6'b010010;
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            if (!stall) break;
            @(posedge clk);
            #1;
            k++;
        end
        chk("mflo_stall_cycles", k, 31);
        chk("mflo_lo", lo, 32'h00030000);
        @(posedge clk);
        #1;
        valid = 1'b0;

        // mthi/mtlo in idle
        valid  = 1'b1;
        funct  = 6'b010001;
        rs_val = 32'h12345678;
        @(posedge clk);
        #1;
        funct  = 6'b010011;
        rs_val = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("mthi_idle", hi, 32'h12345678);
        chk("mtlo_idle", lo, 32'h9ABCDEF0);

        // Reset abort 10 cycles into a div; no result is queued for it.
        valid  = 1'b1;
        funct  = 6'b011010;
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_done", {31'b0, mdu_done}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_mdu("mult_after_rst", 6'b011000, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h3FFFFFFF, 32'h00000001, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
